vx_fifo_reader: RTL

- Read-side companion to the team's FIFO queue. It drives the queue's pop and consumes its empty flag and read data, which arrive after a fixed read latency.
- It presents the data as a valid/ready stream, with full throughput and no bubbles.
- A small internal output buffer absorbs the read latency and downstream backpressure, so pops never overrun it.
- Used wherever a queue with a registered or RAM read feeds a ready-based consumer.

---
 rtl/vx_fifo_pkg.sv | 16 +
 rtl/vx_fifo_reader_if.sv | 30 +++
 rtl/vx_fifo_reader_obuf.sv | 61 ++++++
 rtl/vx_fifo_reader.sv | 101 ++++++++++
 4 files changed

// File: rtl/vx_fifo_pkg.sv
// Shared types and helpers for the FIFO read-side controller.
// The buffer index helper wraps at any depth, not only at powers of two.
package vx_fifo_pkg;

    localparam int unsigned RD_LATENCY_MAX = 3;

    typedef struct packed {
        logic pop;
        logic drop;
    } inflight_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
        return (idx >= depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vx_fifo_reader_if.sv
// Upstream queue read port plus downstream valid/ready stream of the FIFO reader.
// The reader sits on the master side of this interface.
interface vx_fifo_reader_if #(
    parameter int DATAW = 32
);
    logic             fifo_empty;
    logic             fifo_pop;
    logic [DATAW-1:0] fifo_data;
    logic             valid_out;
    logic             ready_out;
    logic [DATAW-1:0] data_out;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  ready_out,
        output fifo_pop,
        output valid_out,
        output data_out
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output ready_out,
        input  fifo_pop,
        input  valid_out,
        input  data_out
    );
endinterface

// File: rtl/vx_fifo_reader_obuf.sv
// Circular output buffer of the FIFO reader: head/tail indices, occupancy and a clear.
// Head is presented directly, so data appears one cycle after it is written.
module vx_fifo_reader_obuf
    import vx_fifo_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int DEPTH = 2,
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCCW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr,
    input  logic [DATAW-1:0] wdata,
    input  logic             rd,
    output logic [DATAW-1:0] rdata,
    output logic [OCCW-1:0]  occ,
    output logic             valid
);

    logic [DATAW-1:0] mem [DEPTH];
    logic [IDXW-1:0]  head;
    logic [IDXW-1:0]  tail;
    logic [OCCW-1:0]  count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                tail <= IDXW'(wrap_inc(32'(tail), DEPTH));
            end
            if (rd) begin
                head <= IDXW'(wrap_inc(32'(head), DEPTH));
            end
            count <= count + OCCW'(wr) - OCCW'(rd);
        end
    end

    // Storage needs no reset: nothing is presented while count is zero.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= wdata;
        end
    end

    assign rdata = mem[head];
    assign occ   = count;
    assign valid = (count != '0);

    a_no_overrun: assert property (@(posedge clk) disable iff (reset)
        wr |-> ((count - OCCW'(rd)) < OCCW'(DEPTH)));

endmodule

// File: rtl/vx_fifo_reader.sv
// Read-side controller for a queue with fixed read latency, presenting a valid/ready stream.
// Pops are credited against buffer space so in-flight reads always have a slot on arrival.
module vx_fifo_reader
    import vx_fifo_pkg::*;
#(
    parameter int DATAW      = 32,
    parameter int RD_LATENCY = 1,
    parameter int OBUF_DEPTH = RD_LATENCY + 1,
    parameter int CNTW       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_fifo_reader_if.master        bus,
    input  logic                    flush,
    output logic                    busy,
    output logic [CNTW-1:0]         delivered
);

    localparam int OCCW = $clog2(OBUF_DEPTH + 1);
    localparam int CRW  = $clog2(OBUF_DEPTH + RD_LATENCY + 1) + 1;

    if (RD_LATENCY < 0 || RD_LATENCY > int'(RD_LATENCY_MAX)) begin : g_bad_latency
        $error("vx_fifo_reader: RD_LATENCY out of range");
    end
    if (OBUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
        $error("vx_fifo_reader: OBUF_DEPTH must be at least RD_LATENCY+1");
    end

    logic             fire;
    logic             pop_req;
    logic             capture;
    logic [OCCW-1:0]  occ;
    logic [CRW-1:0]   inflight;
    logic [CRW-1:0]   credit_used;

    assign fire = bus.valid_out && bus.ready_out;

    // The same-cycle handshake frees a slot, which keeps the stream bubble-free.
    assign credit_used = CRW'(occ) + inflight - CRW'(fire);
    assign pop_req     = !bus.fifo_empty && !flush && (credit_used < CRW'(OBUF_DEPTH));
    assign bus.fifo_pop = pop_req;

    if (RD_LATENCY == 0) begin : g_lat0
        assign capture  = pop_req;
        assign inflight = '0;
    end else begin : g_latn
        inflight_t sr [RD_LATENCY];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < RD_LATENCY; k++) begin
                    sr[k] <= '0;
                end
            end else begin
                sr[0] <= '{pop: pop_req, drop: 1'b0};
                for (int k = 1; k < RD_LATENCY; k++) begin
                    sr[k] <= '{pop: sr[k-1].pop, drop: sr[k-1].drop | flush};
                end
            end
        end

        // An entry arriving during a flush is discarded like any marked one.
        assign capture = sr[RD_LATENCY-1].pop && !sr[RD_LATENCY-1].drop && !flush;

        always_comb begin
            inflight = '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                inflight = inflight + CRW'(sr[k].pop);
            end
        end
    end

    vx_fifo_reader_obuf #(
        .DATAW (DATAW),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .wr    (capture),
        .wdata (bus.fifo_data),
        .rd    (fire),
        .rdata (bus.data_out),
        .occ   (occ),
        .valid (bus.valid_out)
    );

    assign busy = (occ != '0) || (inflight != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delivered <= '0;
        end else begin
            delivered <= delivered + CNTW'(fire);
        end
    end

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (reset)
        bus.fifo_pop |-> !bus.fifo_empty);

endmodule
